uart_tx: RTL and testbench
==========================

# uart_tx

Simple 8-N-1 UART transmitter with a small input FIFO. It accepts bytes from on-chip logic over a valid/ready handshake and serialises them onto a single idle-high line. Each frame is one start bit, eight data bits LSB first, and one stop bit, at a fixed baud rate derived from the main clock. It is the transmit counterpart of the team's `uart_rx`, and the two share the same clock/baud parameterisation.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, main clock frequency in Hz.
- `BAUDRATE`, 9_600, line bit rate.
- `CLK_PER_BIT`, (CLK_HZ / BAUDRATE) - 1, terminal count of the baud counter; one bit lasts CLK_PER_BIT+1 clocks.
- `COUNTER_SIZE`, $clog2(CLK_PER_BIT), baud counter width.
- `FIFO_DEPTH`, 4, input FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`, input, 1, main clock (CLK_HZ); all logic on its rising edge.
- `rst`, input, 1, reset; one clock domain, reset is asynchronous and active-high.
- `data`, input, 8, byte to transmit.
- `send`, input, 1, `data` is valid this cycle.
- `ready`, output, 1, FIFO can accept a byte this cycle.
- `out`, output, 1, serial line, registered, idles high.
- `busy`, output, 1, a frame is in progress.
- `done`, output, 1, one-cycle pulse at the end of each stop bit.

## Operation
- **Accept.** A byte is written into the FIFO on a rising edge where `send && ready`. `send` while `!ready` is ignored; the byte is dropped and no error is flagged.
- **Ready.** `ready = !full`. It is combinational from the FIFO count only and never depends on `send`.
- **FIFO.** Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits and natural wrap-around, plus a count of $clog2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
  - There is no write-to-output bypass: a byte written into an empty FIFO is popped on the following edge.
- **State machine:** IDLE, START, DATA, STOP.
- **IDLE.**
  - With the FIFO non-empty: pop the head into the shift register, clear the baud counter and the bit index, drive `out <= 0`, go to START.
  - Otherwise: `out <= 1`.
- **Baud counter.** Runs in every non-IDLE state. `tick = (counter == CLK_PER_BIT)`. On tick the counter returns to 0; otherwise it increments.
- **START.** On tick: `out <= shift[0]`, go to DATA.
- **DATA.** On tick:
  - Shift the register right and increment the bit index.
  - If the index was 7: `out <= 1`, go to STOP.
  - Otherwise: `out <=` the next bit.
- **STOP.** On tick, pulse `done`, then:
  - If the FIFO is non-empty: pop, `out <= 0`, go to START. Back-to-back frames have no idle gap.
  - Otherwise: go to IDLE with `out` staying 1.
- **busy.** `busy = (state != IDLE)`.
- **Reset values:** `out` = 1, `ready` = 1, `busy` = 0, `done` = 0. Counter, bit index, pointers, count and shift register all 0. State is IDLE.
- **Reset mid-frame.** Aborts immediately and asynchronously: `out` returns high and FIFO contents are discarded. The partial frame on the line is expected to be flagged by the far-end receiver as a framing error.
- **Illegal state encodings** go to IDLE.

## Timing
- **Accept-to-line latency.** Byte accepted at edge t into an empty FIFO with the block IDLE: popped at edge t+1, and `out` falls after edge t+1.
- **Bit widths on the line:**
  - Start bit: CLK_PER_BIT+1 clocks.
  - Each data bit: CLK_PER_BIT+1 clocks.
  - Stop bit: CLK_PER_BIT+1 clocks, measured from `out` rising to the `done` edge.
- **Frame length.** 10 × (CLK_PER_BIT+1) clocks; 52 080 at the defaults.
- **done timing.** `done` is high for exactly one clock, in the cycle after the final stop-bit tick edge, and coincides with either `busy` falling or the next start bit beginning.
- **Freeing a slot.** A pop frees a FIFO slot, so `ready` rises in the cycle after the popping edge when the FIFO was full.
- **Throughput.** Continuous traffic sustains one byte per frame time with `out` never idling between frames.

## Test plan
Simulate with CLK_HZ=16, BAUDRATE=1 (16 clocks/bit) unless stated otherwise.
- **Single byte.** Send 0xA5 once → `out` is low one clock after accept, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then high. `done` pulses 160 clocks after `out` fell. `busy` is high for exactly those 160 clocks.
- **FIFO fill.** Hold `send` with 0x01..0x06 while IDLE → first 5 bytes accepted (1 popped immediately, 4 buffered). `ready` is low until the first frame's stop tick. Bytes then transmit in order, back-to-back, with no high gap beyond the stop bits. 0x06 is accepted only once `ready` rises.
- **Edge-pattern bytes.** Send 0x00 then 0xFF → line low for 9 bits then high for 1 stop bit; then start bit, then high for 9 bits. Check both frames bit-exact.
- **Reset mid-frame.** Assert `rst` during data bit 3 with 2 bytes queued → `out` = 1, `busy` = 0, `ready` = 1 immediately. No further frames after release until a new `send`.
- **Loopback.** Drive `out` into `uart_rx` with default parameters, using 256 random bytes with random gaps → every byte is received with `get` = 1 and `error` = 0, and the data matches in order.
- **Simultaneous push and pop.** Hold the FIFO at count 2 and send a byte on the exact STOP-tick edge → count stays 2, no byte is lost or duplicated, and order is preserved.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8-N-1 UART transmitter with a small input FIFO. Bytes arrive from on-chip
// logic over a valid/ready handshake, are buffered, and are serialised onto an
// idle-high line: one start bit (low), eight data bits LSB first, one stop bit
// (high). Every bit lasts CLK_PER_BIT+1 clocks. Back-to-back frames follow each
// other with no idle gap when the FIFO holds more data.
//
// Ports:
//   clk    in   1  main clock, all logic on its rising edge
//   rst    in   1  asynchronous active-high reset, aborts any frame in flight
//   data   in   8  byte to transmit
//   send   in   1  data is valid this cycle; accepted when send && ready
//   ready  out  1  FIFO can accept a byte this cycle (not full)
//   out    out  1  registered serial line, idles high
//   busy   out  1  a frame is in progress
//   done   out  1  one-cycle pulse after the final stop-bit tick
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUDRATE     = 9_600,
   parameter int CLK_PER_BIT  = (CLK_HZ / BAUDRATE) - 1,
   parameter int COUNTER_SIZE = $clog2(CLK_PER_BIT),
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       send,
   output logic       ready,
   output logic       out,
   output logic       busy,
   output logic       done
);

   localparam int                        PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [COUNTER_SIZE-1:0]   TICK_COUNT = COUNTER_SIZE'(CLK_PER_BIT);
   localparam logic [PTR_W:0]            FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
   logic [2:0]              bit_idx_q, bit_idx_d;
   logic [7:0]              shift_q, shift_d;
   logic                    out_q, out_d;
   logic                    done_q, done_d;

   logic [7:0]              mem_q [FIFO_DEPTH];
   logic [7:0]              mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]          count_q, count_d;

   logic                    push;
   logic                    pop;
   logic                    tick;
   logic                    fifo_empty;
   logic [7:0]              head;

   assign ready      = (count_q != FULL_COUNT);
   assign fifo_empty = (count_q == '0);
   assign head       = mem_q[rd_ptr_q];
   assign push       = send && ready;
   assign tick       = (cnt_q == TICK_COUNT);

   assign out  = out_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

   // FIFO bookkeeping. The FSM only pops when the FIFO is non-empty and the
   // handshake only pushes when it is not full, so the count never wraps.
   // A simultaneous push and pop leaves the count unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Frame sequencing. The baud counter free-runs in every non-idle state and
   // wraps on its terminal count; each state only acts on that tick. The line
   // value is computed one bit ahead so that out_q changes exactly on ticks.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      out_d     = out_q;
      done_d    = 1'b0;
      pop       = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = tick ? '0 : cnt_q + COUNTER_SIZE'(1);
      end

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_d   = head;
               cnt_d     = '0;
               bit_idx_d = '0;
               out_d     = 1'b0;
               state_d   = START;
            end else begin
               out_d = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               out_d   = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  out_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  out_d = shift_q[1];
               end
            end
         end
         STOP: begin
            if (tick) begin
               done_d = 1'b1;
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_d   = head;
                  bit_idx_d = '0;
                  out_d     = 1'b0;
                  state_d   = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            out_d   = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // All state registers. Reset aborts any frame immediately, returns the
   // line high and discards whatever was queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         out_q     <= 1'b1;
         done_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         out_q     <= out_d;
         done_q    <= done_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         mem_q     <= mem_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Testbench for uart_tx at 16 clocks per bit with a 4-entry FIFO. A reference
// model tracks the queued bytes and the start edge of the frame on the line;
// the expected line level is derived from the elapsed clocks since that edge
// (bit slot = elapsed / 16). A table of hand-written frames, directed
// sequences and a randomized traffic phase drive the design.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CLK_HZ     = 16;
   localparam int BAUDRATE   = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int BIT_CLKS   = CLK_HZ / BAUDRATE;
   localparam int FRAME_CLKS = 10 * BIT_CLKS;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       send;
   logic       ready;
   logic       out;
   logic       busy;
   logic       done;

   uart_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUDRATE   (BAUDRATE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .data  (data),
      .send  (send),
      .ready (ready),
      .out   (out),
      .busy  (busy),
      .done  (done)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   logic [7:0] mq [$];
   bit         m_active;
   int         m_start;
   logic [7:0] m_byte;
   bit         m_done;
   bit         m_pushed;
   int         edge_n;

   typedef struct {
      logic [7:0] tx_byte;
      logic [9:0] exp_frame;
   } vec_t;

   vec_t vec_tab [5];

   // Absolute safety net in case something stalls the bench.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_active = 1'b0;
      m_start  = 0;
      m_byte   = '0;
      m_done   = 1'b0;
      m_pushed = 1'b0;
      edge_n   = 0;
   endfunction

   // One rising edge of the model: a frame ends 10 bit times after it began;
   // an idle transmitter (including one whose frame just ended) takes the
   // oldest queued byte; the offered byte is queued if there was room before
   // the edge.
   function automatic void model_edge(input logic s, input logic [7:0] d);
      bit can_push;
      can_push = (mq.size() < FIFO_DEPTH);
      edge_n++;
      m_done   = 1'b0;
      m_pushed = 1'b0;
      if (m_active && (edge_n == m_start + FRAME_CLKS)) begin
         m_done   = 1'b1;
         m_active = 1'b0;
      end
      if (!m_active && (mq.size() > 0)) begin
         m_byte   = mq.pop_front();
         m_active = 1'b1;
         m_start  = edge_n;
      end
      if (s && can_push) begin
         mq.push_back(d);
         m_pushed = 1'b1;
      end
   endfunction

   function automatic logic exp_out();
      int slot;
      if (!m_active) return 1'b1;
      slot = (edge_n - m_start) / BIT_CLKS;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return m_byte[slot-1];
      return 1'b1;
   endfunction

   // Drive one clock of input (called away from the rising edge), advance the
   // model on the edge and compare every output on the following falling edge.
   task automatic applyStimulus(input logic s, input logic [7:0] d);
      send = s;
      data = d;
      @(posedge clk);
      model_edge(s, d);
      @(negedge clk);
      checkOutput($sformatf("out@%0d", edge_n), out, exp_out());
      checkOutput($sformatf("busy@%0d", edge_n), busy, m_active);
      checkOutput($sformatf("done@%0d", edge_n), done, m_done);
      checkOutput($sformatf("ready@%0d", edge_n), ready, (mq.size() < FIFO_DEPTH));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
   endtask

   initial begin
      int busy_cycles;
      int done_cycles;
      int tries;
      int guard;

      // Frame images: bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop.
      vec_tab[0] = '{tx_byte: 8'hA5, exp_frame: 10'b1_10100101_0};
      vec_tab[1] = '{tx_byte: 8'h00, exp_frame: 10'b1_00000000_0};
      vec_tab[2] = '{tx_byte: 8'hFF, exp_frame: 10'b1_11111111_0};
      vec_tab[3] = '{tx_byte: 8'h01, exp_frame: 10'b1_00000001_0};
      vec_tab[4] = '{tx_byte: 8'h80, exp_frame: 10'b1_10000000_0};

      rst  = 1'b1;
      send = 1'b0;
      data = 8'h00;
      model_reset();

      // Reset values while reset is held.
      @(negedge clk);
      checkOutput("reset_out", out, 1'b1);
      checkOutput("reset_ready", ready, 1'b1);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(3);

      // Table of single frames sent from idle, sampled mid-bit.
      for (int t = 0; t < 5; t++) begin
         busy_cycles = 0;
         done_cycles = 0;
         applyStimulus(1'b1, vec_tab[t].tx_byte);
         for (int j = 1; j <= 170; j++) begin
            applyStimulus(1'b0, 8'h00);
            if (j == 1) checkOutput($sformatf("vec%0d_start_fall", t), out, 1'b0);
            if ((j <= FRAME_CLKS) && (((j - 1) % BIT_CLKS) == BIT_CLKS / 2))
               checkOutput($sformatf("vec%0d_slot%0d", t, (j - 1) / BIT_CLKS), out,
                           vec_tab[t].exp_frame[(j - 1) / BIT_CLKS]);
            if (j == FRAME_CLKS + 1) checkOutput($sformatf("vec%0d_done_time", t), done, 1'b1);
            if (busy) busy_cycles++;
            if (done) done_cycles++;
         end
         checkOutput($sformatf("vec%0d_busy_len", t), busy_cycles, FRAME_CLKS);
         checkOutput($sformatf("vec%0d_done_count", t), done_cycles, 1);
      end

      // FIFO fill: hold send with 0x01..0x06 from idle.
      for (int b = 1; b <= 6; b++) begin
         tries = 0;
         applyStimulus(1'b1, 8'(b));
         tries++;
         while (!m_pushed && tries < 400) begin
            applyStimulus(1'b1, 8'(b));
            tries++;
         end
         if (b == 5) checkOutput("fill_ready_low", ready, 1'b0);
         if (b == 6) checkOutput("fill_wait_for_06", tries, 158);
      end
      idle(6 * FRAME_CLKS);

      // Edge-pattern bytes back to back.
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'hFF);
      idle(2 * FRAME_CLKS + 20);

      // Simultaneous push and pop on the stop-tick edge with two queued.
      applyStimulus(1'b1, 8'h11);
      applyStimulus(1'b1, 8'h22);
      applyStimulus(1'b1, 8'h33);
      guard = 0;
      while (!(m_active && (edge_n + 1 == m_start + FRAME_CLKS)) && guard < 400) begin
         applyStimulus(1'b0, 8'h00);
         guard++;
      end
      checkOutput("pushpop_reach_stop", (guard < 400), 1'b1);
      applyStimulus(1'b1, 8'h44);
      checkOutput("pushpop_done", done, 1'b1);
      checkOutput("pushpop_ready", ready, 1'b1);
      applyStimulus(1'b1, 8'h55);
      checkOutput("pushpop_three_left", ready, 1'b1);
      applyStimulus(1'b1, 8'h66);
      checkOutput("pushpop_full_again", ready, 1'b0);
      idle(6 * FRAME_CLKS);

      // Reset during data bit 3 with two bytes queued.
      applyStimulus(1'b1, 8'hC3);
      applyStimulus(1'b1, 8'h5A);
      applyStimulus(1'b1, 8'h96);
      guard = 0;
      while ((edge_n - m_start) != 4 * BIT_CLKS + 6 && guard < 400) begin
         applyStimulus(1'b0, 8'h00);
         guard++;
      end
      checkOutput("rstmid_reach_bit3", (guard < 400), 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstmid_out", out, 1'b1);
      checkOutput("rstmid_busy", busy, 1'b0);
      checkOutput("rstmid_ready", ready, 1'b1);
      checkOutput("rstmid_done", done, 1'b0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(2 * FRAME_CLKS);

      // Randomized traffic: a sparse phase and a congested phase.
      for (int i = 0; i < 1500; i++)
         applyStimulus(($urandom_range(0, 99) < 1), 8'($urandom));
      for (int i = 0; i < 2500; i++)
         applyStimulus(($urandom_range(0, 99) < 8), 8'($urandom));
      idle(6 * FRAME_CLKS);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
